// File: rtl/xillybus_mem_8_responder.sv
//==============================================================================
// Module   : xillybus_mem_8_responder
// Brief    : Seekable byte-array responder for a Xillybus 8-bit memory stream.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module xillybus_mem_8_responder #(
    parameter int          ADDR_W    = 5,
    parameter logic [7:0]  INIT_BYTE = 8'h00
) (
    input  logic              bus_clk,
    input  logic              trn_reset_n,
    input  logic              quiesce,
    input  logic [ADDR_W-1:0] user_mem_8_addr,
    input  logic              user_mem_8_addr_update,
    input  logic              user_w_mem_8_wren,
    input  logic [7:0]        user_w_mem_8_data,
    input  logic              user_w_mem_8_open,
    output logic              user_w_mem_8_full,
    input  logic              user_r_mem_8_rden,
    output logic [7:0]        user_r_mem_8_data,
    output logic              user_r_mem_8_empty,
    output logic              user_r_mem_8_eof,
    input  logic              user_r_mem_8_open
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        data_q, data_d;
    logic              wr_end_q, wr_end_d;
    logic              rd_end_q, rd_end_d;
    logic              open_w_q, open_r_q;

    logic              wr_acc;
    logic              rd_acc;
    logic              ptr_at_end;

    always_comb begin
        wr_acc     = user_w_mem_8_wren & ~wr_end_q & user_w_mem_8_open & ~quiesce;
        rd_acc     = user_r_mem_8_rden & ~rd_end_q & user_r_mem_8_open & ~quiesce;
        ptr_at_end = &ptr_q;

        ptr_d    = ptr_q;
        wr_end_d = wr_end_q;
        rd_end_d = rd_end_q;
        // Array is read before this cycle's write lands, so a same-cycle
        // read/write pair returns the old byte.
        data_d   = rd_acc ? mem_q[ptr_q] : data_q;

        if (wr_acc && ptr_at_end) wr_end_d = 1'b1;
        if (rd_acc && ptr_at_end) rd_end_d = 1'b1;

        if (open_w_q && !user_w_mem_8_open) wr_end_d = 1'b0;
        if (open_r_q && !user_r_mem_8_open) rd_end_d = 1'b0;

        if (quiesce) begin
            wr_end_d = 1'b0;
            rd_end_d = 1'b0;
        end

        // A seek wins over the post-access increment.
        if (user_mem_8_addr_update) begin
            ptr_d    = user_mem_8_addr;
            wr_end_d = 1'b0;
            rd_end_d = 1'b0;
        end else if (wr_acc || rd_acc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge bus_clk) begin
        if (!trn_reset_n) begin
            ptr_q    <= '0;
            data_q   <= 8'h00;
            wr_end_q <= 1'b0;
            rd_end_q <= 1'b0;
            open_w_q <= 1'b0;
            open_r_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_BYTE;
            end
        end else begin
            ptr_q    <= ptr_d;
            data_q   <= data_d;
            wr_end_q <= wr_end_d;
            rd_end_q <= rd_end_d;
            open_w_q <= user_w_mem_8_open;
            open_r_q <= user_r_mem_8_open;
            if (wr_acc) begin
                mem_q[ptr_q] <= user_w_mem_8_data;
            end
        end
    end

    assign user_w_mem_8_full  = wr_end_q;
    assign user_r_mem_8_empty = rd_end_q;
    assign user_r_mem_8_eof   = rd_end_q;
    assign user_r_mem_8_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_xillybus_mem_8_responder.sv
//==============================================================================
// Module   : tb_xillybus_mem_8_responder
// Brief    : Scoreboard bench for the 8-bit memory responder with a byte-array model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_xillybus_mem_8_responder;

    localparam int DEPTH = 32;

    logic       bus_clk = 1'b0;
    logic       trn_reset_n;
    logic       quiesce;
    logic [4:0] user_mem_8_addr;
    logic       user_mem_8_addr_update;
    logic       user_w_mem_8_wren;
    logic [7:0] user_w_mem_8_data;
    logic       user_w_mem_8_open;
    logic       user_w_mem_8_full;
    logic       user_r_mem_8_rden;
    logic [7:0] user_r_mem_8_data;
    logic       user_r_mem_8_empty;
    logic       user_r_mem_8_eof;
    logic       user_r_mem_8_open;

    xillybus_mem_8_responder #(.ADDR_W(5), .INIT_BYTE(8'h00)) dut (
        .bus_clk                (bus_clk),
        .trn_reset_n            (trn_reset_n),
        .quiesce                (quiesce),
        .user_mem_8_addr        (user_mem_8_addr),
        .user_mem_8_addr_update (user_mem_8_addr_update),
        .user_w_mem_8_wren      (user_w_mem_8_wren),
        .user_w_mem_8_data      (user_w_mem_8_data),
        .user_w_mem_8_open      (user_w_mem_8_open),
        .user_w_mem_8_full      (user_w_mem_8_full),
        .user_r_mem_8_rden      (user_r_mem_8_rden),
        .user_r_mem_8_data      (user_r_mem_8_data),
        .user_r_mem_8_empty     (user_r_mem_8_empty),
        .user_r_mem_8_eof       (user_r_mem_8_eof),
        .user_r_mem_8_open      (user_r_mem_8_open)
    );

    always #5 bus_clk = ~bus_clk;

    // Reference model: plain byte array, integer pointer, two end flags.
    byte unsigned m_mem [DEPTH];
    int           m_ptr;
    bit           m_wr_end, m_rd_end;
    bit           m_ow_prev, m_or_prev;
    byte unsigned exp_q[$];
    bit           mon_en = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic model_step();
        bit          wa, ra, nw, nr;
        byte unsigned rd_byte;
        if (!trn_reset_n) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_ptr = 0; m_wr_end = 0; m_rd_end = 0; m_ow_prev = 0; m_or_prev = 0;
            exp_q.delete();
            exp_q.push_back(8'h00);
            return;
        end
        wa = user_w_mem_8_wren && !m_wr_end && user_w_mem_8_open && !quiesce;
        ra = user_r_mem_8_rden && !m_rd_end && user_r_mem_8_open && !quiesce;
        rd_byte = m_mem[m_ptr];
        if (ra) exp_q.push_back(rd_byte);
        if (wa) m_mem[m_ptr] = user_w_mem_8_data;
        nw = m_wr_end || (wa && m_ptr == DEPTH - 1);
        nr = m_rd_end || (ra && m_ptr == DEPTH - 1);
        if (m_ow_prev && !user_w_mem_8_open) nw = 0;
        if (m_or_prev && !user_r_mem_8_open) nr = 0;
        if (quiesce) begin nw = 0; nr = 0; end
        if (user_mem_8_addr_update) begin
            m_ptr = int'(user_mem_8_addr);
            nw = 0; nr = 0;
        end else if (wa || ra) begin
            m_ptr = (m_ptr + 1) % DEPTH;
        end
        m_wr_end = nw; m_rd_end = nr;
        m_ow_prev = user_w_mem_8_open;
        m_or_prev = user_r_mem_8_open;
    endtask

    // Inputs are applied just after the falling edge; one tick = one rising edge.
    task automatic tick();
        model_step();
        @(posedge bus_clk);
        if (!trn_reset_n) mon_en = 1'b1;
        @(negedge bus_clk);
        #1;
    endtask

    task automatic strobes_off();
        user_mem_8_addr_update = 0;
        user_w_mem_8_wren      = 0;
        user_r_mem_8_rden      = 0;
        quiesce                = 0;
    endtask

    task automatic seek(input int a);
        strobes_off();
        user_mem_8_addr = 5'(a);
        user_mem_8_addr_update = 1;
        tick();
        user_mem_8_addr_update = 0;
    endtask

    task automatic wr(input byte unsigned d);
        strobes_off();
        user_w_mem_8_wren = 1; user_w_mem_8_data = d;
        tick();
        user_w_mem_8_wren = 0;
    endtask

    task automatic rd();
        strobes_off();
        user_r_mem_8_rden = 1;
        tick();
        user_r_mem_8_rden = 0;
    endtask

    task automatic idle();
        strobes_off();
        tick();
    endtask

    // Monitor: outputs are stable at the falling edge.
    byte unsigned last_data = 8'h00;
    always @(negedge bus_clk) begin
        if (mon_en) begin
            if (exp_q.size() > 0) last_data = exp_q.pop_front();
            checks++;
            if (user_r_mem_8_data !== last_data) begin
                errors++;
                $display("FAIL rd_data t=%0t got %02h exp %02h", $time, user_r_mem_8_data, last_data);
            end
            checks++;
            if (user_w_mem_8_full !== m_wr_end) begin
                errors++;
                $display("FAIL full t=%0t got %b exp %b", $time, user_w_mem_8_full, m_wr_end);
            end
            checks++;
            if (user_r_mem_8_empty !== m_rd_end || user_r_mem_8_eof !== m_rd_end) begin
                errors++;
                $display("FAIL empty_eof t=%0t got %b/%b exp %b", $time,
                         user_r_mem_8_empty, user_r_mem_8_eof, m_rd_end);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        trn_reset_n = 0;
        strobes_off();
        user_mem_8_addr = 0; user_w_mem_8_data = 0;
        user_w_mem_8_open = 1; user_r_mem_8_open = 1;
        @(negedge bus_clk); #1;
        tick(); tick();
        trn_reset_n = 1;
        idle(); idle();

        // Seek/write/read-back
        seek(5); wr(8'hA1); wr(8'hB2);
        seek(5); rd(); rd(); idle(); idle();

        // Write past the top of the array
        seek(30); wr(8'h11); wr(8'h22); wr(8'h33); idle();
        rd(); idle();
        seek(0); idle();
        seek(30); rd(); rd(); idle();

        // Read the last byte, then sticky empty/eof and open_r release
        seek(31); rd(); rd(); rd(); idle();
        user_r_mem_8_open = 0; idle();
        user_r_mem_8_open = 1; idle();

        // Same-cycle read and write
        seek(10); wr(8'h55);
        seek(10);
        strobes_off();
        user_r_mem_8_rden = 1; user_w_mem_8_wren = 1; user_w_mem_8_data = 8'h77;
        tick(); strobes_off();
        rd(); seek(10); rd(); idle();

        // Seek coincident with write; quiesce blocks access
        seek(20);
        strobes_off();
        user_w_mem_8_wren = 1; user_w_mem_8_data = 8'h9C;
        user_mem_8_addr = 5'd3; user_mem_8_addr_update = 1;
        tick(); strobes_off();
        rd(); seek(20); rd();
        seek(31); wr(8'hEE); idle();
        strobes_off();
        quiesce = 1; user_w_mem_8_wren = 1; user_r_mem_8_rden = 1; user_w_mem_8_data = 8'h01;
        tick(); tick(); strobes_off();
        rd(); rd(); idle();

        // Reset mid write burst
        seek(8);
        for (int i = 0; i < 4; i++) wr(byte'(8'hC0 + i));
        strobes_off();
        user_w_mem_8_wren = 1; user_w_mem_8_data = 8'hDD; trn_reset_n = 0;
        tick();
        trn_reset_n = 1; strobes_off();
        wr(8'h42);
        seek(8); rd(); rd(); seek(0); rd(); idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            strobes_off();
            trn_reset_n            = ($urandom_range(0, 199) != 0);
            quiesce                = ($urandom_range(0, 29) == 0);
            user_mem_8_addr_update = ($urandom_range(0, 9) == 0);
            user_mem_8_addr        = 5'($urandom_range(0, DEPTH - 1));
            user_w_mem_8_wren      = ($urandom_range(0, 1) == 1);
            user_w_mem_8_data      = 8'($urandom);
            user_r_mem_8_rden      = ($urandom_range(0, 1) == 1);
            user_w_mem_8_open      = ($urandom_range(0, 19) != 0);
            user_r_mem_8_open      = ($urandom_range(0, 19) != 0);
            tick();
        end
        trn_reset_n = 1; strobes_off();
        idle(); idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
